// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES block type, CBC sequencer state encoding and mode constants
//
// Purpose : common definitions imported by the CBC sequencer.
// Contents: des_block_t  - 64-bit DES block, bit 0 is the MSB
//           cbc_state_t  - sequencer states (IDLE, WAIT_DATA, CORE, OUT)
//           DES_MODE_ENC / DES_MODE_DEC - values driven on the core mode input
package des_pkg;

   typedef logic [0:63] des_block_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      CORE      = 2'd2,
      OUT       = 2'd3
   } cbc_state_t;

   localparam logic DES_MODE_ENC = 1'b1;
   localparam logic DES_MODE_DEC = 1'b0;

endpackage

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - CBC-mode sequencer driving an external DES core one block at a time
//
// Purpose : accepts a key, IV and a stream of 64-bit blocks, applies CBC chaining for
//           encryption or decryption, hands each block to the DES core beside it and
//           returns results on a valid/ready stream. One block is in flight at a time.
// Ports   : clk, reset           - clock, synchronous active-low reset
//           start_i, mode_i      - begin a message (1 = encrypt, 0 = decrypt)
//           key_i, iv_i          - DES key and initial chaining value, sampled on start
//           s_valid_i/s_data_i/s_last_i/s_ready_o - input block stream
//           m_valid_o/m_data_o/m_last_o/m_ready_i - result block stream
//           des_mode_o/des_key_o/des_data_o/des_valid_o - request to the DES core
//           des_data_i/des_valid_i - result from the DES core
//           busy_o               - sequencer is not idle
//           error_o              - sticky core-timeout flag, cleared by the next start
module des_cbc_ctrl
   import des_pkg::*;
#(
   parameter int TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        mode_i,
   input  logic [0:63] key_i,
   input  logic [0:63] iv_i,
   input  logic        s_valid_i,
   input  logic [0:63] s_data_i,
   input  logic        s_last_i,
   output logic        s_ready_o,
   output logic        m_valid_o,
   output logic [0:63] m_data_o,
   output logic        m_last_o,
   input  logic        m_ready_i,
   output logic        des_mode_o,
   output logic [0:63] des_key_o,
   output logic [0:63] des_data_o,
   output logic        des_valid_o,
   input  logic [0:63] des_data_i,
   input  logic        des_valid_i,
   output logic        busy_o,
   output logic        error_o
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   cbc_state_t    state_q;
   des_block_t    chain_q;
   des_block_t    hold_q;
   des_block_t    m_data_q;
   des_block_t    des_key_q;
   des_block_t    des_data_q;
   logic          des_mode_q;
   logic          des_valid_q;
   logic          last_q;
   logic          s_ready_q;
   logic          m_valid_q;
   logic          m_last_q;
   logic          error_q;
   logic [TW-1:0] timer_q;

   logic [TW-1:0] timer_d;
   des_block_t    result_d;
   des_block_t    chain_d;
   logic          accept;
   logic          timeout_hit;

   always_comb begin
      accept = s_valid_i & s_ready_q;

      // Saturating counter of cycles spent waiting in CORE.
      timer_d     = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
      timeout_hit = (timer_d == TIMER_MAX);

      // Encrypt chains on the ciphertext just produced; decrypt chains on the
      // ciphertext that went into the core, which was parked in hold_q.
      if (des_mode_q == DES_MODE_ENC) begin
         result_d = des_data_i;
         chain_d  = des_data_i;
      end else begin
         result_d = des_data_i ^ chain_q;
         chain_d  = hold_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         chain_q     <= '0;
         hold_q      <= '0;
         m_data_q    <= '0;
         des_key_q   <= '0;
         des_data_q  <= '0;
         des_mode_q  <= 1'b0;
         des_valid_q <= 1'b0;
         last_q      <= 1'b0;
         s_ready_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         error_q     <= 1'b0;
         timer_q     <= '0;
      end else begin
         // The core request is a single-cycle pulse.
         des_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  des_key_q  <= key_i;
                  des_mode_q <= mode_i;
                  chain_q    <= iv_i;
                  error_q    <= 1'b0;
                  s_ready_q  <= 1'b1;
                  state_q    <= WAIT_DATA;
               end
            end

            WAIT_DATA: begin
               if (accept) begin
                  des_data_q  <= (des_mode_q == DES_MODE_ENC) ? (s_data_i ^ chain_q) : s_data_i;
                  hold_q      <= s_data_i;
                  last_q      <= s_last_i;
                  des_valid_q <= 1'b1;
                  timer_q     <= '0;
                  s_ready_q   <= 1'b0;
                  state_q     <= CORE;
               end
            end

            CORE: begin
               // A result arriving in the timeout cycle still wins.
               if (des_valid_i) begin
                  m_data_q  <= result_d;
                  chain_q   <= chain_d;
                  m_valid_q <= 1'b1;
                  m_last_q  <= last_q;
                  state_q   <= OUT;
               end else if (timeout_hit) begin
                  error_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  timer_q <= timer_d;
               end
            end

            OUT: begin
               if (m_ready_i) begin
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
                  if (last_q) begin
                     state_q <= IDLE;
                  end else begin
                     s_ready_q <= 1'b1;
                     state_q   <= WAIT_DATA;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_ready_o   = s_ready_q;
   assign m_valid_o   = m_valid_q;
   assign m_data_o    = m_data_q;
   assign m_last_o    = m_last_q;
   assign des_mode_o  = des_mode_q;
   assign des_key_o   = des_key_q;
   assign des_data_o  = des_data_q;
   assign des_valid_o = des_valid_q;
   assign busy_o      = (state_q != IDLE);
   assign error_o     = error_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb/tb_des_cbc_ctrl.sv - self-checking bench for des_cbc_ctrl with a behavioural DES core
module tb_des_cbc_ctrl;

   localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam int SHF_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int IP_T  [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   localparam int FP_T  [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   localparam int E_T   [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                 16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   localparam int P_T   [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   localparam int SBOX_T [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // Single-block DES; table positions count from 1 at the MSB.
   function automatic logic [63:0] des_ecb(input logic [63:0] key, input logic [63:0] din, input logic enc);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] sk [16];
      logic [47:0] er;
      logic [63:0] x, y;
      logic [31:0] l, r, nl, so, f;
      logic [5:0]  six;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int s = 0; s < SHF_T[rd]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[56-PC2_T[i]];
      end
      for (int i = 0; i < 64; i++) x[63-i] = din[64-IP_T[i]];
      l = x[63:32];
      r = x[31:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int i = 0; i < 48; i++) er[47-i] = r[32-E_T[i]];
         er = er ^ (enc ? sk[rd] : sk[15-rd]);
         for (int j = 0; j < 8; j++) begin
            six = er[47-6*j -: 6];
            so[31-4*j -: 4] = 4'(SBOX_T[j][{six[5], six[0], six[4:1]}]);
         end
         for (int i = 0; i < 32; i++) f[31-i] = so[32-P_T[i]];
         nl = r;
         r  = l ^ f;
         l  = nl;
      end
      y = {r, l};
      for (int i = 0; i < 64; i++) x[63-i] = y[64-FP_T[i]];
      return x;
   endfunction

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic        mode_i = 1'b0;
   logic [0:63] key_i = '0;
   logic [0:63] iv_i = '0;
   logic        s_valid_i = 1'b0;
   logic [0:63] s_data_i = '0;
   logic        s_last_i = 1'b0;
   logic        s_ready_o;
   logic        m_valid_o;
   logic [0:63] m_data_o;
   logic        m_last_o;
   logic        m_ready_i = 1'b0;
   logic        des_mode_o;
   logic [0:63] des_key_o;
   logic [0:63] des_data_o;
   logic        des_valid_o;
   logic [0:63] des_data_i = '0;
   logic        des_valid_i = 1'b0;
   logic        busy_o;
   logic        error_o;

   des_cbc_ctrl #(.TIMEOUT(31)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i), .key_i(key_i), .iv_i(iv_i),
      .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
      .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
      .des_mode_o(des_mode_o), .des_key_o(des_key_o), .des_data_o(des_data_o), .des_valid_o(des_valid_o),
      .des_data_i(des_data_i), .des_valid_i(des_valid_i), .busy_o(busy_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int core_lat = 1;
   bit core_en = 1'b1;

   logic [63:0] msg_blk [4];
   logic [63:0] exp_blk [4];

   typedef struct packed {
      logic             mode;
      logic [63:0]      key;
      logic [63:0]      iv;
      logic [3:0]       n;
      logic [2:0][63:0] blk;
      logic [2:0][63:0] exp;
   } vec_t;
   vec_t vecs [4];

   // DES core model: capture a request, answer after core_lat further cycles.
   initial begin : core_model
      logic [63:0] ck, cdat;
      logic        cm;
      forever begin
         @(negedge clk);
         if (des_valid_o && core_en) begin
            ck   = des_key_o;
            cdat = des_data_o;
            cm   = des_mode_o;
            repeat (core_lat) @(negedge clk);
            des_data_i  = des_ecb(ck, cdat, cm);
            des_valid_i = 1'b1;
            @(negedge clk);
            des_valid_i = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // CBC reference: chaining value is the previous ciphertext in both directions.
   task automatic cbc_ref(input logic m, input logic [63:0] k, input logic [63:0] iv, input int n);
      logic [63:0] prev;
      prev = iv;
      for (int i = 0; i < n; i++) begin
         if (m) begin
            exp_blk[i] = des_ecb(k, msg_blk[i] ^ prev, 1'b1);
            prev = exp_blk[i];
         end else begin
            exp_blk[i] = des_ecb(k, msg_blk[i], 1'b0) ^ prev;
            prev = msg_blk[i];
         end
      end
   endtask

   task automatic start_msg(input logic m, input logic [63:0] k, input logic [63:0] iv);
      start_i = 1'b1;
      mode_i  = m;
      key_i   = k;
      iv_i    = iv;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] d, input logic last);
      int n;
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = last;
      n = 0;
      while (!s_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready_o) chk("s_ready_wait", 64'(s_ready_o), 64'd1);
      @(negedge clk);
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   task automatic recv_block(input bit bp, output logic [63:0] d, output logic l);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      d = '0;
      l = 1'b0;
      while (!done && n < 200) begin
         if (m_valid_o && !(bp && $urandom_range(0, 2) == 0)) begin
            d = m_data_o;
            l = m_last_o;
            m_ready_i = 1'b1;
            @(negedge clk);
            m_ready_i = 1'b0;
            done = 1'b1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (!done) chk("m_valid_wait", 64'(m_valid_o), 64'd1);
   endtask

   task automatic run_msg(input string tag, input logic m, input logic [63:0] k, input logic [63:0] iv,
                          input int n, input bit bp);
      logic [63:0] d;
      logic        l;
      start_msg(m, k, iv);
      for (int i = 0; i < n; i++) begin
         send_block(msg_blk[i], i == n - 1);
         recv_block(bp, d, l);
         chk({tag, "_data"}, d, exp_blk[i]);
         chk({tag, "_last"}, 64'(l), 64'(i == n - 1));
      end
      chk({tag, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   initial begin : main
      logic [63:0] d, k1, iv1;
      logic        l;
      int          n;

      vecs[0] = '{mode: 1'b1, key: 64'h0123456789ABCDEF, iv: 64'h1234567890ABCDEF, n: 4'd3,
                  blk: {64'h666F7220616C6C20, 64'h68652074696D6520, 64'h4E6F772069732074},
                  exp: {64'h683788499A7C05F6, 64'h43E934008C389C0F, 64'hE5C7CDDE872BF27C}};
      vecs[1] = '{mode: 1'b0, key: 64'h0123456789ABCDEF, iv: 64'h1234567890ABCDEF, n: 4'd3,
                  blk: {64'h683788499A7C05F6, 64'h43E934008C389C0F, 64'hE5C7CDDE872BF27C},
                  exp: {64'h666F7220616C6C20, 64'h68652074696D6520, 64'h4E6F772069732074}};
      vecs[2] = '{mode: 1'b1, key: 64'h0123456789ABCDEF, iv: 64'h0, n: 4'd1,
                  blk: {64'h0, 64'h0, 64'h4E6F772069732074},
                  exp: {64'h0, 64'h0, 64'h3FA40E8A984D4815}};
      vecs[3] = '{mode: 1'b0, key: 64'h0123456789ABCDEF, iv: 64'h0, n: 4'd1,
                  blk: {64'h0, 64'h0, 64'h3FA40E8A984D4815},
                  exp: {64'h0, 64'h0, 64'h4E6F772069732074}};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 64'({s_ready_o, m_valid_o, m_last_o, des_mode_o, des_valid_o, busy_o, error_o}), 64'd0);
      chk("rst_m_data", m_data_o, 64'd0);
      chk("rst_des_key", des_key_o, 64'd0);
      chk("rst_des_data", des_data_o, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Known-answer vectors
      core_lat = 3;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < int'(vecs[v].n); i++) begin
            msg_blk[i] = vecs[v].blk[i];
            exp_blk[i] = vecs[v].exp[i];
         end
         run_msg($sformatf("kat%0d", v), vecs[v].mode, vecs[v].key, vecs[v].iv, int'(vecs[v].n), 1'b0);
      end

      // Latency and backpressure
      core_lat = 2;
      k1 = {$urandom, $urandom};
      iv1 = {$urandom, $urandom};
      msg_blk[0] = {$urandom, $urandom};
      msg_blk[1] = {$urandom, $urandom};
      cbc_ref(1'b1, k1, iv1, 2);
      start_msg(1'b1, k1, iv1);
      send_block(msg_blk[0], 1'b0);
      chk("lat_des_valid_n1", 64'(des_valid_o), 64'd1);
      @(negedge clk);
      chk("lat_des_valid_n2", 64'(des_valid_o), 64'd0);
      @(negedge clk);
      chk("lat_m_valid_n3", 64'(m_valid_o), 64'd0);
      @(negedge clk);
      chk("lat_m_valid_n4", 64'(m_valid_o), 64'd1);
      chk("bp_data", m_data_o, exp_blk[0]);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_hold_data", m_data_o, exp_blk[0]);
         chk("bp_hold_valid", 64'(m_valid_o), 64'd1);
         chk("bp_s_ready", 64'(s_ready_o), 64'd0);
         chk("bp_des_valid", 64'(des_valid_o), 64'd0);
      end
      m_ready_i = 1'b1;
      @(negedge clk);
      m_ready_i = 1'b0;
      chk("bp_single_handshake", 64'(m_valid_o), 64'd0);
      chk("bp_next_ready", 64'(s_ready_o), 64'd1);
      send_block(msg_blk[1], 1'b1);
      recv_block(1'b0, d, l);
      chk("bp_blk1_data", d, exp_blk[1]);
      chk("bp_blk1_last", 64'(l), 64'd1);

      // start_i during WAIT_DATA is ignored
      core_lat = 1;
      k1 = {$urandom, $urandom};
      iv1 = {$urandom, $urandom};
      msg_blk[0] = {$urandom, $urandom};
      cbc_ref(1'b1, k1, iv1, 1);
      start_msg(1'b1, k1, iv1);
      start_i = 1'b1;
      mode_i = 1'b0;
      key_i = ~k1;
      iv_i = ~iv1;
      @(negedge clk);
      start_i = 1'b0;
      chk("restart_key", des_key_o, k1);
      chk("restart_mode", 64'(des_mode_o), 64'd1);
      send_block(msg_blk[0], 1'b1);
      recv_block(1'b0, d, l);
      chk("restart_data", d, exp_blk[0]);

      // Result in the last cycle before timeout is taken
      core_lat = 30;
      msg_blk[0] = {$urandom, $urandom};
      cbc_ref(1'b0, k1, iv1, 1);
      run_msg("lat30", 1'b0, k1, iv1, 1, 1'b0);
      chk("lat30_no_error", 64'(error_o), 64'd0);

      // Timeout with a silent core
      core_en = 1'b0;
      start_msg(1'b0, k1, iv1);
      send_block({$urandom, $urandom}, 1'b0);
      chk("to_des_valid", 64'(des_valid_o), 64'd1);
      repeat (30) @(negedge clk);
      chk("to_err_before", 64'(error_o), 64'd0);
      chk("to_busy_before", 64'(busy_o), 64'd1);
      @(negedge clk);
      chk("to_err_set", 64'(error_o), 64'd1);
      chk("to_idle", 64'(busy_o), 64'd0);
      des_data_i = {$urandom, $urandom};
      des_valid_i = 1'b1;
      @(negedge clk);
      des_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("to_stray_ignored", 64'(m_valid_o), 64'd0);
         @(negedge clk);
      end
      chk("to_err_sticky", 64'(error_o), 64'd1);
      core_en = 1'b1;
      core_lat = 2;
      msg_blk[0] = {$urandom, $urandom};
      cbc_ref(1'b1, k1, iv1, 1);
      start_msg(1'b1, k1, iv1);
      chk("to_err_cleared", 64'(error_o), 64'd0);
      send_block(msg_blk[0], 1'b1);
      recv_block(1'b0, d, l);
      chk("to_recover_data", d, exp_blk[0]);

      // Reset in CORE; the late core result must be dropped
      core_lat = 6;
      start_msg(1'b1, k1, iv1);
      send_block({$urandom, $urandom}, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_ctrl", 64'({s_ready_o, m_valid_o, m_last_o, des_mode_o, des_valid_o, busy_o, error_o}), 64'd0);
      chk("mrst_m_data", m_data_o, 64'd0);
      chk("mrst_des_key", des_key_o, 64'd0);
      chk("mrst_des_data", des_data_o, 64'd0);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("mrst_late_result", 64'({m_valid_o, busy_o}), 64'd0);
      end

      // Randomised messages against the reference model
      for (int t = 0; t < 15; t++) begin
         core_lat = $urandom_range(0, 6);
         n = $urandom_range(1, 4);
         k1 = {$urandom, $urandom};
         iv1 = {$urandom, $urandom};
         for (int i = 0; i < n; i++) msg_blk[i] = {$urandom, $urandom};
         l = 1'($urandom_range(0, 1));
         cbc_ref(l, k1, iv1, n);
         run_msg($sformatf("rnd%0d", t), l, k1, iv1, n, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_cbc_ctrl.md
# des_cbc_ctrl

CBC-mode sequencer wrapping the shared `des` core. It accepts a key, an IV and a stream of 64-bit blocks, and handles XOR chaining for both encryption and decryption. It drives the core one block at a time and returns results over a valid/ready stream. It sits between the system data path and the `des` instance; the core is instantiated beside it, not inside it.

## Interface

Parameters:
- `TIMEOUT`, default 31: maximum number of cycles to wait for the core result before flagging an error.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `start_i`  in  1  begin a message; samples `key_i`, `iv_i`, `mode_i`
- `mode_i`  in  1  1 = encrypt, 0 = decrypt
- `key_i`  in  64  DES key, bit 0 = MSB
- `iv_i`  in  64  initial chaining value
- `s_valid_i`  in  1  input block valid
- `s_data_i`  in  64  input block
- `s_last_i`  in  1  final block of the message
- `s_ready_o`  out  1  controller accepts an input block
- `m_valid_o`  out  1  result valid
- `m_data_o`  out  64  result block
- `m_last_o`  out  1  result is the final block
- `m_ready_i`  in  1  downstream accepts the result
- `des_mode_o`  out  1  to core `mode_i`
- `des_key_o`  out  64  to core `key_i`
- `des_data_o`  out  64  to core `data_i`
- `des_valid_o`  out  1  to core `valid_i`
- `des_data_i`  in  64  from core `data_o`
- `des_valid_i`  in  1  from core `valid_o`
- `busy_o`  out  1  state is not IDLE
- `error_o`  out  1  sticky timeout flag

## Operation

States and transitions:
- **IDLE**
  - `s_ready_o`=0.
  - On `start_i`: latch key and mode, load chain register with `iv_i`, clear `error_o`, go to WAIT_DATA.
- **WAIT_DATA**
  - `s_ready_o`=1.
  - On accept (`s_valid_i` & `s_ready_o`), encrypt: `des_data_o` <= `s_data_i` ^ chain.
  - On accept, decrypt: `des_data_o` <= `s_data_i`, and `hold` <= `s_data_i`.
  - Latch `s_last_i`, pulse `des_valid_o` for one cycle, clear the timer, go to CORE.
- **CORE**
  - Waits for `des_valid_i`.
  - Encrypt: result = `des_data_i`; chain <= `des_data_i`.
  - Decrypt: result = `des_data_i` ^ chain; chain <= `hold`.
  - On result: register it into `m_data_o`, set `m_valid_o`, go to OUT.
  - Timer reaching `TIMEOUT` without `des_valid_i`: set `error_o`, go to IDLE.
- **OUT**
  - `m_valid_o`, `m_data_o` and `m_last_o` are held stable until `m_ready_i`.
  - On handshake: go to IDLE if last, else WAIT_DATA.

Boundary rules:
- `start_i` is ignored outside IDLE.
- `des_valid_i` is ignored outside CORE; this includes stale results after timeout or reset.
- Exactly one block is in flight at a time, so no result FIFO is needed.
- `des_key_o` and `des_mode_o` are held constant for the whole message.
- Timer width is `$clog2(TIMEOUT+1)`; it saturates and does not wrap.
- `error_o` stays set until the next `start_i` is accepted.

## Timing

Reset values (`reset`=0 at a clock edge), applied on the next edge:
- State returns to IDLE.
- All outputs are 0, including `des_*_o`, `busy_o` and `error_o`.
- Chain, hold and timer registers are cleared.
- This applies in any state, mid-message included.

Latency and throughput:
- Input accepted at edge N → `des_valid_o` high in cycle N+1.
- Core latency L → `des_valid_i` at N+1+L → `m_valid_o` high at N+2+L.
- With `m_ready_i` tied high, the next `s_ready_o` is at N+3+L, so minimum block period is L+3 cycles.

Handshake and ordering:
- `s_ready_o` is high only in WAIT_DATA, and is a registered output.
- `des_valid_i` arriving in the same cycle the timer hits `TIMEOUT`: the result wins and no error is set.

## Structure

- Package `des_pkg` holds:
  - `des_block_t` (logic [0:63]);
  - the state enum `cbc_state_t` (IDLE, WAIT_DATA, CORE, OUT);
  - constants `DES_MODE_ENC`=1 and `DES_MODE_DEC`=0.
- Single module, no sub-module.
- Top-level wiring to the core goes in a separate `des_cbc_top`.

## Test plan

1. **CBC encrypt (FIPS 81 vector).**
   - Stimulus: key 0123456789ABCDEF, IV 1234567890ABCDEF, blocks 4E6F772069732074, 68652074696D6520, 666F7220616C6C20.
   - Response: E5C7CDDE872BF27C, 43E934008C389C0F, 683788499A7C05F6; `m_last_o` on the third; then IDLE.
2. **CBC decrypt.** Same key and IV with those three ciphertexts → original plaintexts in order.
3. **Backpressure.**
   - Stimulus: `m_ready_i`=0 for 10 cycles in OUT.
   - Response: `m_data_o` stable, `s_ready_o`=0, `des_valid_o`=0 throughout; release → single handshake.
4. **Timeout.**
   - Stimulus: core model never asserts `des_valid_i`; `TIMEOUT`=31.
   - Response: `error_o`=1 after 31 cycles in CORE, state IDLE; a later stray `des_valid_i` causes no `m_valid_o`; next `start_i` clears `error_o`.
5. **Reset mid-message.**
   - Stimulus: `reset`=0 during CORE.
   - Response: all outputs 0 on the next edge; a pending core result after reset is ignored.
6. **Single-block edge cases.**
   - IV 0000000000000000, one block with `s_last_i`=1 → output equals the ECB result of that block.
   - `start_i` pulsed during WAIT_DATA → no change to key or chain.
